// File: rtl/plane_war_pkg.sv
// Shared plane-war screen geometry and coordinate widths.
package plane_war_pkg;

   localparam int X_W   = 12;
   localparam int Y_W   = 10;
   localparam int X_MAX = 550;
   localparam int Y_MAX = 480;

   // Width of an index into a table of 'slots' entries, never zero.
   function automatic int slot_idx_w(input int slots);
      return (slots > 1) ? $clog2(slots) : 1;
   endfunction

endpackage

// File: rtl/first_free_slot.sv
// Priority encoder: index of the lowest-numbered clear bit of the alive vector.
module first_free_slot
   import plane_war_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int IDX_W = slot_idx_w(SLOTS)
) (
   input  logic [SLOTS-1:0] alive,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan downward so the lowest free index is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!alive[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/enemy_spawner.sv
// Enemy table: periodic spawn at a random x, per-frame descent, retirement on hit or bottom escape.
// Optional macro SPAWN_RAMP_EN: spawn period shrinks by 1/8 every 16 spawns, floored at MIN_PERIOD.
module enemy_spawner
   import plane_war_pkg::*;
#(
   parameter int SLOTS        = 4,
   parameter int X_MAX        = plane_war_pkg::X_MAX,
   parameter int Y_MAX        = plane_war_pkg::Y_MAX,
   parameter int SPAWN_PERIOD = 60,
   parameter int MIN_PERIOD   = 20,
   parameter int MOVE_STEP    = 2,
   localparam int IDX_W       = slot_idx_w(SLOTS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_tick,
   input  logic [X_W-1:0]         rand_x,
   input  logic                   hit_valid,
   input  logic [IDX_W-1:0]       hit_slot,
   output logic [SLOTS-1:0]       enemy_alive,
   output logic [SLOTS*X_W-1:0]   enemy_x,
   output logic [SLOTS*Y_W-1:0]   enemy_y,
   output logic                   escape_pulse,
   output logic [15:0]            spawn_count
);

   localparam logic [X_W-1:0] X_LAST      = X_W'(X_MAX - 1);
   localparam logic [Y_W:0]   Y_LIM       = (Y_W + 1)'(Y_MAX);
   localparam logic [Y_W:0]   STEP        = (Y_W + 1)'(MOVE_STEP);
   localparam logic [15:0]    PERIOD_INIT = 16'(SPAWN_PERIOD);

   logic [15:0]      fcnt;
   logic [15:0]      period;
   logic             spawn_attempt;
   logic             spawn_now;
   logic             slot_found;
   logic [IDX_W-1:0] free_idx;
   logic [X_W-1:0]   spawn_x;
   logic [SLOTS-1:0] hit_now;
   logic [SLOTS-1:0] escape_now;
   logic [Y_W:0]     moved_y [SLOTS];

   // Looks at the registered alive vector, so slots freed this cycle wait a cycle.
   first_free_slot #(.SLOTS(SLOTS), .IDX_W(IDX_W)) u_free (
      .alive (enemy_alive),
      .idx   (free_idx),
      .found (slot_found)
   );

   assign spawn_attempt = frame_tick && (fcnt == period - 16'd1);
   assign spawn_now     = spawn_attempt && slot_found;
   assign spawn_x       = (rand_x >= X_LAST) ? X_LAST : rand_x;

   // A hit beats a same-cycle escape, so a killed slot never raises the pulse.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         moved_y[i]    = {1'b0, enemy_y[i*Y_W +: Y_W]} + STEP;
         hit_now[i]    = hit_valid && (hit_slot == IDX_W'(i));
         escape_now[i] = frame_tick && enemy_alive[i] && !hit_now[i] && (moved_y[i] >= Y_LIM);
      end
   end

`ifdef SPAWN_RAMP_EN
   localparam logic [15:0] PERIOD_FLOOR = 16'(MIN_PERIOD);

   logic [15:0] ramp_dec;
   logic [15:0] ramp_next;

   always_comb begin
      ramp_dec  = (period < 16'd8) ? 16'd1 : (period >> 3);
      ramp_next = period - ramp_dec;
      if (ramp_next < PERIOD_FLOOR) ramp_next = PERIOD_FLOOR;
   end

   // Every 16th successful spawn tightens the period used by the following attempt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period <= PERIOD_INIT;
      end else if (spawn_now && (spawn_count[3:0] == 4'hF)) begin
         period <= ramp_next;
      end
   end
`else
   assign period = PERIOD_INIT;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt         <= '0;
         enemy_alive  <= '0;
         enemy_x      <= '0;
         enemy_y      <= '0;
         escape_pulse <= 1'b0;
         spawn_count  <= '0;
      end else begin
         escape_pulse <= |escape_now;
         if (frame_tick) begin
            fcnt <= spawn_attempt ? 16'd0 : fcnt + 16'd1;
         end
         for (int i = 0; i < SLOTS; i++) begin
            if (hit_now[i]) begin
               enemy_alive[i] <= 1'b0;
            end else if (frame_tick && enemy_alive[i]) begin
               if (escape_now[i]) enemy_alive[i] <= 1'b0;
               else               enemy_y[i*Y_W +: Y_W] <= moved_y[i][Y_W-1:0];
            end
         end
         // The spawn slot was dead at cycle start, so it takes no move or hit here.
         if (spawn_now) begin
            enemy_alive[free_idx]            <= 1'b1;
            enemy_x[free_idx*X_W +: X_W]     <= spawn_x;
            enemy_y[free_idx*Y_W +: Y_W]     <= '0;
            spawn_count                      <= spawn_count + 16'd1;
         end
      end
   end

endmodule
